// File: rtl/squares_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | squares_pkg : shared geometry constants, colour and square-entry types   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package squares_pkg;

  localparam int ROW_PIXELS  = 401;
  localparam int SCREEN_ROWS = 480;

  typedef logic [23:0] color_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] size;
    color_t     color;
  } square_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/square_hit_test.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | square_hit_test : coverage and outer-edge test of one square at (x, y)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module square_hit_test (
  input  logic [9:0] i_x0,
  input  logic [8:0] i_y0,
  input  logic [8:0] i_size,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_hit,
  output logic       o_edge
);

  // 11-bit extents so a square near the right or bottom margin never wraps
  logic [10:0] w_x0, w_x1, w_y0, w_y1, w_px, w_py;

  assign w_x0 = {1'b0, i_x0};
  assign w_x1 = w_x0 + {2'b00, i_size};
  assign w_y0 = {2'b00, i_y0};
  assign w_y1 = w_y0 + {2'b00, i_size};
  assign w_px = {1'b0, i_x};
  assign w_py = {2'b00, i_y};

  assign o_hit = (i_size != 9'd0) &&
                 (w_px >= w_x0) && (w_px < w_x1) &&
                 (w_py >= w_y0) && (w_py < w_y1);

  assign o_edge = (w_px == w_x0) || (w_px == w_x1 - 11'd1) ||
                  (w_py == w_y0) || (w_py == w_y1 - 11'd1);

endmodule
`default_nettype wire

// File: rtl/row_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | row_renderer : renders one row of filled squares into a line buffer per  |
// | next_row pulse. Optional macro SQUARE_BORDER_EN draws 1-pixel edges.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module row_renderer #(
  parameter int NUM_SQUARES = 4,
  parameter int ROW_PIXELS  = squares_pkg::ROW_PIXELS,
  parameter int SCREEN_ROWS = squares_pkg::SCREEN_ROWS
) (
  input  logic        clock_vga,
  input  logic        reset_n,
  input  logic        next_row,
  input  logic        next_screen,
  input  logic        sq_we,
  input  logic [1:0]  sq_idx,
  input  logic [9:0]  sq_x,
  input  logic [8:0]  sq_y,
  input  logic [8:0]  sq_size,
  input  logic [23:0] sq_color,
  input  logic [23:0] bg_color,
  input  logic [23:0] border_color,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        overrun
);

  import squares_pkg::*;

  square_t r_shadow    [NUM_SQUARES];
  square_t r_active    [NUM_SQUARES];
  square_t w_shadow_nx [NUM_SQUARES];
  square_t w_table     [NUM_SQUARES];

  state_t r_state, w_state_nx;

  logic [8:0] r_x, r_y, r_y_cur;
  logic [8:0] w_row_y, w_y_inc, w_issue_x, w_issue_y;
  logic       w_start, w_issue, w_last_x;

  logic [NUM_SQUARES-1:0] w_hit, w_edge;
  color_t                 w_pix;

  logic       r_s1_valid;
  logic [8:0] r_s1_addr;
  color_t     r_s1_color;
  logic       r_wr_en;
  logic [8:0] r_wr_addr;
  color_t     r_wr_data;
  logic       r_overrun;

  // Shadow table with this cycle's write merged in, so a copy on next_screen sees it
  always_comb begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      w_shadow_nx[i] = r_shadow[i];
      if (sq_we && (sq_idx == 2'(i))) begin
        w_shadow_nx[i].x     = sq_x;
        w_shadow_nx[i].y     = sq_y;
        w_shadow_nx[i].size  = sq_size;
        w_shadow_nx[i].color = sq_color;
      end
    end
  end

  always_ff @(posedge clock_vga or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SQUARES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SQUARES; i++) begin
        r_shadow[i] <= w_shadow_nx[i];
        if (next_screen) r_active[i] <= w_shadow_nx[i];
      end
    end
  end

  // Pixel 0 is issued in the next_row cycle itself; RENDER then issues 1..ROW_PIXELS-1
  assign w_start   = (r_state == ST_IDLE) && next_row;
  assign w_last_x  = (r_x == 9'(ROW_PIXELS - 1));
  assign w_row_y   = next_screen ? 9'd0 : r_y;
  assign w_y_inc   = (w_row_y == 9'(SCREEN_ROWS - 1)) ? 9'd0 : w_row_y + 9'd1;
  assign w_issue   = w_start || (r_state == ST_RENDER);
  assign w_issue_x = (r_state == ST_RENDER) ? r_x : 9'd0;
  assign w_issue_y = (r_state == ST_RENDER) ? r_y_cur : w_row_y;

  always_comb begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      w_table[i] = (w_start && next_screen) ? w_shadow_nx[i] : r_active[i];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:   if (next_row) w_state_nx = ST_RENDER;
      ST_RENDER: if (w_last_x) w_state_nx = ST_FLUSH;
      ST_FLUSH:  if (r_wr_en && (r_wr_addr == 9'(ROW_PIXELS - 1))) w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_vga or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clock_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= 9'd0;
      r_y     <= 9'd0;
      r_y_cur <= 9'd0;
    end else if (w_start) begin
      r_x     <= 9'd1;
      r_y_cur <= w_row_y;
      r_y     <= w_y_inc;
    end else begin
      if (next_screen) r_y <= 9'd0;
      r_x <= ((r_state == ST_RENDER) && !w_last_x) ? r_x + 9'd1 : 9'd0;
    end
  end

  for (genvar gi = 0; gi < NUM_SQUARES; gi++) begin : g_hit
    square_hit_test u_hit (
      .i_x0   (w_table[gi].x),
      .i_y0   (w_table[gi].y),
      .i_size (w_table[gi].size),
      .i_x    ({1'b0, w_issue_x}),
      .i_y    (w_issue_y),
      .o_hit  (w_hit[gi]),
      .o_edge (w_edge[gi])
    );
  end

  // Descending scan so the lowest-index hit is the one left standing
  always_comb begin
    w_pix = bg_color;
    for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
`ifdef SQUARE_BORDER_EN
        w_pix = w_edge[i] ? border_color : w_table[i].color;
`else
        w_pix = w_table[i].color;
`endif
      end
    end
  end

`ifndef SQUARE_BORDER_EN
  logic w_unused_border;
  assign w_unused_border = ^{border_color, w_edge};
`endif

  always_ff @(posedge clock_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= 9'd0;
      r_s1_color <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 9'd0;
      r_wr_data  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_addr  <= w_issue_x;
      r_s1_color <= w_pix;
      r_wr_en    <= r_s1_valid;
      r_wr_addr  <= r_s1_addr;
      r_wr_data  <= r_s1_color;
      if (next_row && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_row_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_row_renderer : directed self-checking bench for row_renderer          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_row_renderer;

  // Short frame keeps the row-wrap scenario within a small cycle budget
  localparam int          TB_ROWS = 4;
  localparam logic [23:0] BG      = 24'h102030;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BORD    = 24'hFFFF00;

  logic        clock_vga = 1'b0;
  logic        reset_n = 1'b0;
  logic        next_row = 1'b0;
  logic        next_screen = 1'b0;
  logic        sq_we = 1'b0;
  logic [1:0]  sq_idx = 2'd0;
  logic [9:0]  sq_x = 10'd0;
  logic [8:0]  sq_y = 9'd0;
  logic [8:0]  sq_size = 9'd0;
  logic [23:0] sq_color = 24'd0;
  logic [23:0] bg_color = BG;
  logic [23:0] border_color = BORD;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        overrun;

  row_renderer #(
    .NUM_SQUARES (4),
    .ROW_PIXELS  (401),
    .SCREEN_ROWS (TB_ROWS)
  ) u_dut (
    .clock_vga    (clock_vga),
    .reset_n      (reset_n),
    .next_row     (next_row),
    .next_screen  (next_screen),
    .sq_we        (sq_we),
    .sq_idx       (sq_idx),
    .sq_x         (sq_x),
    .sq_y         (sq_y),
    .sq_size      (sq_size),
    .sq_color     (sq_color),
    .bg_color     (bg_color),
    .border_color (border_color),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clock_vga = ~clock_vga;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] row_px [512];
  logic [23:0] exp_px [401];
  int n_wr, first_k, last_k, busy_cnt, order_err, max_addr, bad_addr;

  // All tasks start and end 1 ns after a rising edge
  task automatic set_sq(input int idx, input int x, input int y, input int size,
                        input logic [23:0] col, input bit screen);
    sq_we = 1'b1; sq_idx = 2'(idx); sq_x = 10'(x); sq_y = 9'(y);
    sq_size = 9'(size); sq_color = col; next_screen = screen;
    @(posedge clock_vga); #1;
    sq_we = 1'b0; next_screen = 1'b0;
  endtask

  task automatic run_row(input bit screen, input int extra_k);
    n_wr = 0; first_k = -1; last_k = -1; busy_cnt = 0; order_err = 0; max_addr = 0;
    for (int a = 0; a < 512; a++) row_px[a] = 'x;
    next_row = 1'b1; next_screen = screen;
    @(posedge clock_vga); #1;
    next_row = 1'b0; next_screen = 1'b0;
    for (int k = 1; k <= 460; k++) begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        if (int'(wr_addr) != n_wr) order_err++;
        if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
        row_px[wr_addr] = wr_data;
        n_wr++;
      end
      if (k == extra_k) next_row = 1'b1;
      @(posedge clock_vga); #1;
      next_row = 1'b0;
    end
  endtask

  task automatic fill_exp(input int lo, input int hi, input logic [23:0] col);
    for (int a = lo; a <= hi; a++) exp_px[a] = col;
  endtask

  function automatic int row_errors();
    int errs = 0;
    bad_addr = -1;
    for (int a = 0; a < 401; a++) begin
      if (row_px[a] !== exp_px[a]) begin
        errs++;
        if (bad_addr < 0) bad_addr = a;
      end
    end
    return errs;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock_vga);
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 9'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== 24'd0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset_n = 1'b1;
    repeat (2) @(posedge clock_vga);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_empty_row();
    int e;
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    n_cmp++; if (n_wr !== 401) begin n_bad++; $display("FAIL empty_count: got %0d want 401", n_wr); end
    n_cmp++; if (first_k !== 2) begin n_bad++; $display("FAIL empty_first_write: got cycle %0d want 2", first_k); end
    n_cmp++; if (last_k !== 402) begin n_bad++; $display("FAIL empty_last_write: got cycle %0d want 402", last_k); end
    n_cmp++; if (busy_cnt !== 402) begin n_bad++; $display("FAIL empty_busy_cycles: got %0d want 402", busy_cnt); end
    n_cmp++; if (order_err !== 0) begin n_bad++; $display("FAIL empty_addr_order: got %0d out-of-order want 0", order_err); end
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL empty_pixels: got %0d bad (first addr %0d) want 0", e, bad_addr); end
  endtask

  task automatic test_single_square();
    int e;
    set_sq(0, 10, 0, 5, RED, 1'b0);
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL shadow_not_active: got %0d bad (first addr %0d) want 0", e, bad_addr); end
    next_screen = 1'b1;
    @(posedge clock_vga); #1;
    next_screen = 1'b0;
    run_row(1'b0, 0);
    fill_exp(10, 14, RED);
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL single_square: got %0d bad (first addr %0d) want 0", e, bad_addr); end
    n_cmp++; if (row_px[14] !== RED) begin n_bad++; $display("FAIL single_last_col: got %h want %h", row_px[14], RED); end
  endtask

  task automatic test_priority();
    int e;
    set_sq(0, 0, 0, 20, RED, 1'b0);
    set_sq(1, 5, 0, 20, BLUE, 1'b1);
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    fill_exp(0, 19, RED);
    fill_exp(20, 24, BLUE);
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL priority: got %0d bad (first addr %0d) want 0", e, bad_addr); end
    n_cmp++; if (row_px[5] !== RED) begin n_bad++; $display("FAIL priority_overlap: got %h want %h", row_px[5], RED); end
  endtask

  task automatic test_right_edge();
    int e;
    set_sq(1, 0, 0, 0, BLUE, 1'b0);
    set_sq(0, 398, 0, 10, RED, 1'b1);
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    fill_exp(398, 400, RED);
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL right_edge: got %0d bad (first addr %0d) want 0", e, bad_addr); end
    n_cmp++; if (n_wr !== 401) begin n_bad++; $display("FAIL right_edge_count: got %0d want 401", n_wr); end
    n_cmp++; if (max_addr !== 400) begin n_bad++; $display("FAIL right_edge_max_addr: got %0d want 400", max_addr); end
  endtask

  task automatic test_y_wrap();
    set_sq(0, 50, 0, 1, GREEN, 1'b0);
    run_row(1'b1, 0);
    n_cmp++; if (row_px[50] !== GREEN) begin n_bad++; $display("FAIL coincide_row0: got %h want %h", row_px[50], GREEN); end
    n_cmp++; if (row_px[51] !== BG) begin n_bad++; $display("FAIL coincide_width: got %h want %h", row_px[51], BG); end
    for (int r = 1; r < TB_ROWS; r++) run_row(1'b0, 0);
    n_cmp++; if (row_px[50] !== BG) begin n_bad++; $display("FAIL last_row: got %h want %h", row_px[50], BG); end
    run_row(1'b0, 0);
    n_cmp++; if (row_px[50] !== GREEN) begin n_bad++; $display("FAIL y_wrap: got %h want %h", row_px[50], GREEN); end
  endtask

  task automatic test_border();
    int e;
    set_sq(0, 10, 0, 5, RED, 1'b1);
    run_row(1'b0, 0);
    run_row(1'b0, 0);
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    fill_exp(10, 14, RED);
`ifdef SQUARE_BORDER_EN
    exp_px[10] = BORD;
    exp_px[14] = BORD;
`endif
    e = row_errors();
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL border_row2: got %0d bad (first addr %0d) want 0", e, bad_addr); end
  endtask

  task automatic test_overrun();
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_before: got %b want 0", overrun); end
    run_row(1'b0, 100);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_cmp++; if (n_wr !== 401) begin n_bad++; $display("FAIL overrun_count: got %0d want 401", n_wr); end
    n_cmp++; if (last_k !== 402) begin n_bad++; $display("FAIL overrun_last_write: got cycle %0d want 402", last_k); end
    n_cmp++; if (busy_cnt !== 402) begin n_bad++; $display("FAIL overrun_busy: got %0d want 402", busy_cnt); end
    run_row(1'b0, 0);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_row();
    int cnt;
    int e;
    next_row = 1'b1;
    @(posedge clock_vga); #1;
    next_row = 1'b0;
    repeat (49) @(posedge clock_vga);
    #1;
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL midrow_writing: got %b want 1", wr_en); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midrow_reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrow_reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL midrow_reset_overrun: got %b want 0", overrun); end
    repeat (5) @(posedge clock_vga);
    #1 reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock_vga); #1;
      if (wr_en) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL aborted_row_writes: got %0d want 0", cnt); end
    run_row(1'b0, 0);
    fill_exp(0, 400, BG);
    e = row_errors();
    n_cmp++; if (n_wr !== 401) begin n_bad++; $display("FAIL resume_count: got %0d want 401", n_wr); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL tables_cleared: got %0d bad (first addr %0d) want 0", e, bad_addr); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock_vga); #1;
    test_reset();
    test_empty_row();
    test_single_square();
    test_priority();
    test_right_edge();
    test_y_wrap();
    test_border();
    test_overrun();
    test_reset_mid_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/row_renderer.md
ROW_RENDERER -- requirements
Module: row_renderer

Interface
REQ-001 SHALL have parameter NUM_SQUARES, default 4, number of square table entries (index width 2).
REQ-002 SHALL have parameter ROW_PIXELS, default 401, pixels rendered per row (visible columns 80..480 of the streamer).
REQ-003 SHALL have parameter SCREEN_ROWS, default 480, rows per frame.
REQ-004 Ports, clock and reset first:
- clock_vga  in  1  single clock, rising edge; one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- next_row  in  1  one-cycle pulse from the streamer: render the following row.
- next_screen  in  1  one-cycle pulse from the streamer: frame end.
- sq_we  in  1  write strobe for the shadow square table.
- sq_idx  in  2  entry written.
- sq_x  in  10  left column, 0..400.
- sq_y  in  9  top row, 0..479.
- sq_size  in  9  side length in pixels; 0 disables the entry.
- sq_color  in  24  RGB 8:8:8 fill.
- bg_color  in  24  background colour.
- border_color  in  24  edge colour, used only under REQ-021.
- wr_en  out  1  line-buffer write enable.
- wr_addr  out  9  line-buffer address, 0..ROW_PIXELS-1.
- wr_data  out  24  pixel colour.
- busy  out  1  high while rendering.
- overrun  out  1  sticky: next_row arrived while busy.

Function
REQ-005 SHALL hold two tables: shadow (written by sq_we, same cycle) and active (used for rendering).
REQ-006 On next_screen, SHALL copy shadow to active and set row index y to 0; a sq_we in the same cycle SHALL land in shadow and in the copied value.
REQ-007 FSM states IDLE, RENDER, FLUSH; IDLE->RENDER on next_row; RENDER->FLUSH when x = ROW_PIXELS-1; FLUSH->IDLE after the final write.
REQ-008 On entering RENDER SHALL latch y_cur = y and advance y to y+1, wrapping SCREEN_ROWS-1 -> 0.
REQ-009 If next_row and next_screen coincide, SHALL apply next_screen first and render row 0.
REQ-010 RENDER SHALL step x from 0 to ROW_PIXELS-1, one pixel per cycle.
REQ-011 Pipeline: hit-test one stage, output register one stage; pixel x SHALL appear on wr_en/wr_addr/wr_data 2 cycles after the cycle x is issued; first write 2 cycles after next_row; last write at cycle ROW_PIXELS+1.
REQ-012 Square i SHALL hit when sq_size != 0, sq_x <= x < sq_x+sq_size and sq_y <= y_cur < sq_y+sq_size; sums SHALL be 11 bits wide, with no wrap.
REQ-013 Lowest-index hitting square SHALL win; with no hit, wr_data SHALL be bg_color.
REQ-014 busy SHALL be high from the cycle after next_row through the last write.
REQ-015 next_row while busy SHALL be ignored and SHALL set overrun; only reset clears overrun.
REQ-016 Writes lead the streamer by >=118 cycles; a single line buffer SHALL suffice and no read-side handshake exists.

Reset
REQ-017 Asynchronous assertion SHALL force IDLE, x=0, y=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, overrun=0 immediately.
REQ-018 Both tables SHALL reset to size 0; deassertion mid-frame SHALL resume at the next next_row.
REQ-019 Reset mid-RENDER SHALL abort the row; no further writes.

Configuration
REQ-020 Macro SQUARE_BORDER_EN SHALL select edge drawing.
REQ-021 Defined: a hit pixel on a square's outer 1-pixel edge (x or y equal to the first or last covered coordinate) SHALL use border_color.
REQ-022 Undefined: border_color SHALL be ignored and hits SHALL use sq_color; the port list is unchanged.

Structure
REQ-023 Package squares_pkg SHALL hold ROW_PIXELS, SCREEN_ROWS, the 24-bit colour typedef and the square-entry struct (x, y, size, color).
REQ-024 Sub-module square_hit_test SHALL evaluate one entry (hit, edge); NUM_SQUARES instances are used.

Verification
REQ-025 Reset, empty table, next_row -> 401 writes addr 0..400 of bg_color, first write 2 cycles later, busy high 402 cycles.
REQ-026 sq0 {x=10,y=0,size=5,red}, next_screen then next_row -> addr 10..14 red, all others bg.
REQ-027 sq0 {x=0,y=0,size=20,red} and sq1 {x=5,y=0,size=20,blue} -> addr 5..19 red (priority), 20..24 blue.
REQ-028 sq0 {x=398,size=10} -> red at 398..400 only, no write beyond 400; y wraps 479 -> 0 without next_screen.
REQ-029 next_row at cycle 100 of RENDER -> ignored, overrun=1, row completes; reset_n low mid-row -> wr_en=0 that cycle.
REQ-030 With SQUARE_BORDER_EN: sq0 {x=10,y=0,size=5} on row 2 -> border at addr 10 and 14, sq_color at 11..13.
